// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit RISC CPU: field widths, opcodes and phase encodings.
package cpu_pkg;

  localparam int unsigned OPW = 3;
  localparam int unsigned PHW = 3;

  localparam logic [OPW-1:0] OpHlt = 3'd0;
  localparam logic [OPW-1:0] OpSkz = 3'd1;
  localparam logic [OPW-1:0] OpAdd = 3'd2;
  localparam logic [OPW-1:0] OpAnd = 3'd3;
  localparam logic [OPW-1:0] OpXor = 3'd4;
  localparam logic [OPW-1:0] OpLda = 3'd5;
  localparam logic [OPW-1:0] OpSto = 3'd6;
  localparam logic [OPW-1:0] OpJmp = 3'd7;

  typedef enum logic [PHW-1:0] {
    PhInstAddr  = 3'd0,
    PhInstFetch = 3'd1,
    PhInstLoad  = 3'd2,
    PhIdle      = 3'd3,
    PhOpAddr    = 3'd4,
    PhOpFetch   = 3'd5,
    PhAluOp     = 3'd6,
    PhStore     = 3'd7
  } phase_e;

  // Opcodes that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [OPW-1:0] op);
    return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational decode of phase, opcode and zero flag into datapath strobes.
module ctrl_decode
  import cpu_pkg::*;
(
  input  phase_e          phase_i,
  input  logic [OPW-1:0]  opcode_i,
  input  logic            zero_i,
  input  logic            halted_i,
  output logic            sel_o,
  output logic            rd_o,
  output logic            wr_o,
  output logic            ld_ir_o,
  output logic            ld_ac_o,
  output logic            inc_pc_o,
  output logic            ld_pc_o,
  output logic            data_e_o,
  output logic            halt_o
);

  logic aluop;
  assign aluop = is_aluop(opcode_i);

  always_comb begin
    sel_o    = 1'b0;
    rd_o     = 1'b0;
    wr_o     = 1'b0;
    ld_ir_o  = 1'b0;
    ld_ac_o  = 1'b0;
    inc_pc_o = 1'b0;
    ld_pc_o  = 1'b0;
    data_e_o = 1'b0;
    halt_o   = 1'b0;
    if (halted_i) begin
      halt_o = 1'b1;
    end else begin
      unique case (phase_i)
        PhInstAddr: sel_o = 1'b1;
        PhInstFetch: begin
          sel_o = 1'b1;
          rd_o  = 1'b1;
        end
        PhInstLoad, PhIdle: begin
          sel_o   = 1'b1;
          rd_o    = 1'b1;
          ld_ir_o = 1'b1;
        end
        PhOpAddr: begin
          inc_pc_o = 1'b1;
          halt_o   = (opcode_i == OpHlt);
        end
        PhOpFetch: rd_o = aluop;
        PhAluOp: begin
          rd_o     = aluop;
          inc_pc_o = (opcode_i == OpSkz) && zero_i;
          ld_pc_o  = (opcode_i == OpJmp);
          data_e_o = (opcode_i == OpSto);
        end
        PhStore: begin
          rd_o     = aluop;
          ld_ac_o  = aluop;
          ld_pc_o  = (opcode_i == OpJmp);
          wr_o     = (opcode_i == OpSto);
          data_e_o = (opcode_i == OpSto);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// CPU sequencer: 8-phase instruction counter plus sticky halt flag; strobes come from ctrl_decode.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           sel,
  output logic           rd,
  output logic           wr,
  output logic           ld_ir,
  output logic           ld_ac,
  output logic           inc_pc,
  output logic           ld_pc,
  output logic           data_e,
  output logic           halt,
  output logic [PHW-1:0] phase
);

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   halt_set;

  // Halting edge also freezes the phase so it stays parked at OP_ADDR.
  assign halt_set = en && !halted_q && (phase_q == PhOpAddr) && (opcode == OpHlt);

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q | halt_set;
    if (en && !halted_q && !halt_set) begin
      phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PhInstAddr;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  assign phase = phase_q;

  ctrl_decode u_ctrl_decode (
    .phase_i  (phase_q),
    .opcode_i (opcode),
    .zero_i   (zero),
    .halted_i (halted_q),
    .sel_o    (sel),
    .rd_o     (rd),
    .wr_o     (wr),
    .ld_ir_o  (ld_ir),
    .ld_ac_o  (ld_ac),
    .inc_pc_o (inc_pc),
    .ld_pc_o  (ld_pc),
    .data_e_o (data_e),
    .halt_o   (halt)
  );

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller with per-phase expected strobe tables.
module tb_cpu_controller;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt;
  logic [2:0] phase;
  logic [8:0] outs;

  int n_cmp = 0;
  int n_err = 0;

  cpu_controller dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .wr     (wr),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  // Bit order: sel rd wr ld_ir ld_ac inc_pc ld_pc data_e halt
  assign outs = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};

  localparam logic [8:0] VSel  = 9'b1_0_0_0_0_0_0_0_0;
  localparam logic [8:0] VHalt = 9'b0_0_0_0_0_0_0_0_1;

  // Per-phase tables, phase 0 in the most significant 9 bits.
  localparam logic [71:0] TAdd = {9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                                  9'b000001000, 9'b010000000, 9'b010000000, 9'b010010000};
  localparam logic [71:0] TSto = {9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                                  9'b000001000, 9'b000000000, 9'b000000010, 9'b001000010};
  localparam logic [71:0] TSkz1 = {9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                                   9'b000001000, 9'b000000000, 9'b000001000, 9'b000000000};
  localparam logic [71:0] TSkz0 = {9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                                   9'b000001000, 9'b000000000, 9'b000000000, 9'b000000000};
  localparam logic [71:0] TJmp = {9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
                                  9'b000001000, 9'b000000000, 9'b000000100, 9'b000000100};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus-protocol invariants, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      n_cmp++;
      if (rd && wr) begin
        n_err++;
        $display("FAIL rd_wr_excl: rd=%b wr=%b at phase %0d, required not both 1", rd, wr, phase);
      end
      n_cmp++;
      if (rd && data_e) begin
        n_err++;
        $display("FAIL rd_data_e_excl: rd=%b data_e=%b at phase %0d, required not both 1",
                 rd, data_e, phase);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic z, input logic [71:0] tbl,
                           input string name);
    logic [8:0] exp_v;
    opcode = op;
    zero   = z;
    for (int i = 0; i < 8; i++) begin
      exp_v = tbl[(7-i)*9 +: 9];
      n_cmp++;
      if (phase !== 3'(i)) begin
        n_err++;
        $display("FAIL %s_phase: got %0d, required %0d", name, phase, i);
      end
      n_cmp++;
      if (outs !== exp_v) begin
        n_err++;
        $display("FAIL %s_outs_ph%0d: got %b, required %b", name, i, outs, exp_v);
      end
      step();
    end
    n_cmp++;
    if (phase !== 3'd0) begin
      n_err++;
      $display("FAIL %s_wrap: got phase %0d, required 0", name, phase);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en     = 1'b0;
    opcode = 3'd2;
    zero   = 1'b0;
    #12;
    n_cmp++;
    if (phase !== 3'd0) begin
      n_err++;
      $display("FAIL reset_phase: got %0d, required 0", phase);
    end
    n_cmp++;
    if (outs !== VSel) begin
      n_err++;
      $display("FAIL reset_outs: got %b, required %b", outs, VSel);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (phase !== 3'd0) begin
      n_err++;
      $display("FAIL en0_hold: got phase %0d, required 0", phase);
    end
    en = 1'b1;
  endtask

  task automatic test_halt();
    opcode = 3'd0;
    zero   = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (phase !== 3'd4 || outs !== 9'b000001001) begin
      n_err++;
      $display("FAIL hlt_op_addr: got phase %0d outs %b, required 4 / 000001001", phase, outs);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (phase !== 3'd4 || outs !== VHalt) begin
        n_err++;
        $display("FAIL hlt_frozen_%0d: got phase %0d outs %b, required 4 / %b",
                 i, phase, outs, VHalt);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (phase !== 3'd0 || outs !== VSel) begin
      n_err++;
      $display("FAIL hlt_async_reset: got phase %0d outs %b, required 0 / %b", phase, outs, VSel);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stall();
    int budget;
    opcode = 3'd6;
    zero   = 1'b0;
    budget = 0;
    step();
    while (phase !== 3'd7 && budget < 16) begin
      step();
      budget++;
    end
    n_cmp++;
    if (phase !== 3'd7) begin
      n_err++;
      $display("FAIL stall_reach_store: got phase %0d, required 7 within 16 clocks", phase);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (phase !== 3'd7 || wr !== 1'b1 || data_e !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got phase %0d wr %b data_e %b, required 7 / 1 / 1",
                 i, phase, wr, data_e);
      end
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (phase !== 3'd0 || wr !== 1'b0) begin
      n_err++;
      $display("FAIL stall_resume: got phase %0d wr %b, required 0 / 0", phase, wr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    run_instr(3'd2, 1'b0, TAdd, "add");
    run_instr(3'd6, 1'b0, TSto, "sto");
    run_instr(3'd1, 1'b1, TSkz1, "skz_z1");
    run_instr(3'd1, 1'b0, TSkz0, "skz_z0");
    run_instr(3'd7, 1'b0, TJmp, "jmp");
    test_halt();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
